// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with one write port and two read ports.
// After reset is released, a clear sequence writes zero to every entry.
// Busy is high during that sequence, and user writes are ignored.
// Each read port can return its data either combinationally or through a
// one-cycle output register. An optional write-bypass forwards D straight
// to a read port when that port addresses the entry being written.
//
// Parameters
//   DATA_WIDTH   bits per entry
//   ADDR_WIDTH   address bits, DEPTH = 2**ADDR_WIDTH entries
//   NoConfigBits width of ConfigBits (bits [2:0] are used)
//
// Ports
//   UserCLK     in   1             rising-edge clock
//   UserRST_N   in   1             asynchronous active-low reset
//   D           in   DATA_WIDTH    write data
//   W_ADR       in   ADDR_WIDTH    write address
//   W_en        in   1             write enable, active high
//   A_ADR       in   ADDR_WIDTH    read port A address
//   AD          out  DATA_WIDTH    read port A data
//   B_ADR       in   ADDR_WIDTH    read port B address
//   BD          out  DATA_WIDTH    read port B data
//   Busy        out  1             high while the clear sequence runs
//   ConfigBits  in   NoConfigBits  static: [0] A registered,
//                                  [1] B registered, [2] write bypass
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int NoConfigBits = 3
) (
    input  logic                    UserCLK,
    input  logic                    UserRST_N,
    input  logic [DATA_WIDTH-1:0]   D,
    input  logic [ADDR_WIDTH-1:0]   W_ADR,
    input  logic                    W_en,
    input  logic [ADDR_WIDTH-1:0]   A_ADR,
    output logic [DATA_WIDTH-1:0]   AD,
    input  logic [ADDR_WIDTH-1:0]   B_ADR,
    output logic [DATA_WIDTH-1:0]   BD,
    output logic                    Busy,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // The clear pointer has one spare bit, so it can reach DEPTH without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    // Storage: no reset. Contents become zero only through the clear sequence.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q,   state_d;
    logic [ADDR_WIDTH:0]   clr_ptr_q, clr_ptr_d;
    logic                  busy_q,    busy_d;
    logic [DATA_WIDTH-1:0] ad_reg_q,  ad_reg_d;
    logic [DATA_WIDTH-1:0] bd_reg_q,  bd_reg_d;

    logic                  a_reg_en;
    logic                  b_reg_en;
    logic                  bypass_en;

    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    assign a_reg_en  = ConfigBits[0];
    assign b_reg_en  = ConfigBits[1];
    assign bypass_en = ConfigBits[2];

    // ---- combinational read (stage 0) ----
    // The read ports return zero while Busy is high. Busy is high exactly
    // while the FSM is in CLEAR, so the bypass can only fire in READY.
    always_comb begin
        rd_a = '0;
        if (!busy_q) begin
            if (bypass_en && W_en && (A_ADR == W_ADR)) begin
                rd_a = D;
            end else begin
                rd_a = mem[A_ADR];
            end
        end
    end

    always_comb begin
        rd_b = '0;
        if (!busy_q) begin
            if (bypass_en && W_en && (B_ADR == W_ADR)) begin
                rd_b = D;
            end else begin
                rd_b = mem[B_ADR];
            end
        end
    end

    // ---- write-port selection ----
    // In CLEAR the clear sequence owns the write port and user writes are dropped.
    // While reset is held the FSM stays in CLEAR, so any in-flight user write
    // is discarded as well.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = W_ADR;
        mem_wd = D;
        if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr_q[ADDR_WIDTH-1:0];
            mem_wd = '0;
        end else if (W_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // ---- control next-state ----
    // The edge that clears entry DEPTH-1 also moves the FSM to READY and drops Busy.
    // As a result, CLEAR lasts exactly DEPTH cycles.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        if (state_q == S_CLEAR) begin
            clr_ptr_d = clr_ptr_q + PTR_ONE;
            if (clr_ptr_q == LAST_PTR) begin
                state_d = S_READY;
                busy_d  = 1'b0;
            end
        end
        ad_reg_d = rd_a;
        bd_reg_d = rd_b;
    end

    // ---- output registers (stage 1) ----
    always_ff @(posedge UserCLK or negedge UserRST_N) begin
        if (!UserRST_N) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            ad_reg_q  <= '0;
            bd_reg_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            ad_reg_q  <= ad_reg_d;
            bd_reg_q  <= bd_reg_d;
        end
    end

    // The registered path is already zero under reset. The combinational
    // path is gated by Busy, so both outputs read zero in every configuration.
    assign AD   = a_reg_en ? ad_reg_q : rd_a;
    assign BD   = b_reg_en ? bd_reg_q : rd_b;
    assign Busy = busy_q;

endmodule
